// File: rtl/store_spill.sv
`default_nettype none
// ============================================================================
// Module   : store_spill
// Purpose  : Splits a Memory-stage store into one or two XLEN-aligned write
//            beats when the store crosses an XLEN/8-byte boundary. Each beat
//            carries lane-aligned write data and a byte mask. The pipeline is
//            stalled until every beat of an accepted store has been accepted
//            by memory.
// Revision : 1.0 - initial release
// ============================================================================
module store_spill #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StoreValidM,
  output logic              StoreReadyM,
  input  logic              FlushM,
  input  logic [XLEN-1:0]   StoreAdrM,
  input  logic [XLEN-1:0]   StoreDataM,
  input  logic [1:0]        StoreSizeM,
  output logic              MemWriteValid,
  input  logic              MemWriteReady,
  output logic [XLEN-1:0]   MemWriteAdr,
  output logic [XLEN-1:0]   MemWriteData,
  output logic [XLEN/8-1:0] MemByteMask,
  output logic              MemSecondBeat,
  output logic              SpillStallM
);

  localparam int B  = XLEN / 8;
  localparam int LB = $clog2(B);
  // Bytes per beat, sized to hold offset + length without overflow.
  localparam logic [LB:0] B_LANES = (LB + 1)'(B);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  adr_q;
  logic [XLEN-1:0]  data_q;
  logic [1:0]       size_q;

  logic             accept;
  logic [1:0]       size_in;
  logic [LB-1:0]    off;
  logic [LB:0]      nbytes;
  logic [LB:0]      end_off;
  logic [LB:0]      rem_off;
  logic             spill;
  logic [B-1:0]     mask_base;
  logic [XLEN-1:0]  base_adr;

  assign StoreReadyM = (state == IDLE);
  assign SpillStallM = (state != IDLE);
  assign accept      = StoreValidM & StoreReadyM & ~FlushM;

  // A 32-bit datapath has no doubleword store; fold size 3 onto a word.
  assign size_in = ((XLEN == 32) && (StoreSizeM == 2'd3)) ? 2'd2 : StoreSizeM;

  // Geometry of the captured store: lane offset, length and whether it spills.
  assign off       = adr_q[LB-1:0];
  assign nbytes    = (LB + 1)'(1) << size_q;
  assign end_off   = {1'b0, off} + nbytes;
  assign rem_off   = B_LANES - {1'b0, off};
  assign spill     = (end_off > B_LANES);
  assign mask_base = {B{1'b1}} >> (B_LANES - nbytes);
  assign base_adr  = {adr_q[XLEN-1:LB], {LB{1'b0}}};

  // Request capture and beat sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      adr_q  <= '0;
      data_q <= '0;
      size_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= FIRST;
            adr_q  <= StoreAdrM;
            data_q <= StoreDataM;
            size_q <= size_in;
          end
        end
        FIRST: begin
          if (MemWriteReady) begin
            state <= spill ? SECOND : IDLE;
          end
        end
        SECOND: begin
          if (MemWriteReady) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat presentation: decoded from state and captured fields only, so the
  // beat stays stable while memory back-pressures. Idle outputs are zero.
  always_comb begin
    MemWriteValid = 1'b0;
    MemSecondBeat = 1'b0;
    MemWriteAdr   = '0;
    MemWriteData  = '0;
    MemByteMask   = '0;
    case (state)
      FIRST: begin
        MemWriteValid = 1'b1;
        MemWriteAdr   = base_adr;
        MemWriteData  = data_q << {off, 3'b000};
        MemByteMask   = mask_base << off;
      end
      SECOND: begin
        MemWriteValid = 1'b1;
        MemSecondBeat = 1'b1;
        MemWriteAdr   = base_adr + XLEN'(B);
        MemWriteData  = data_q >> {rem_off, 3'b000};
        MemByteMask   = mask_base >> rem_off;
      end
      default: begin
        MemWriteValid = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
